uart_tx_fifo: RTL

Transmit-side byte buffer that sits directly upstream of the UART transmitter inside `uart_top`. It accepts bytes from the host with a valid/ready handshake and stores them in a circular FIFO. It hands the bytes to the transmitter one frame at a time, using a start pulse and the transmitter's busy flag. This decouples host write bursts from the baud-rate-limited serial line.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_tx_fifo_if.sv | 37 +++
 rtl/uart_sync_fifo.sv | 67 ++++++
 rtl/uart_tx_fifo.sv | 83 ++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and transmit-buffer FSM state encoding.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StStart    = 2'd1,
    StWaitAck  = 2'd2,
    StWaitDone = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between the host, the transmit buffer and the UART transmitter.
//   wr_data/wr_valid/wr_ready : host byte write handshake
//   flush                     : synchronous FIFO clear
//   tx_busy                   : transmitter is shifting a frame
//   tx_data/tx_start          : byte and launch pulse to the transmitter
//   count/empty/full/overflow : buffer status
interface uart_tx_fifo_if
  import uart_pkg::*;
#(
  parameter int unsigned ADDR_W = 4
);

  logic [UART_DATA_W-1:0] wr_data;
  logic                   wr_valid;
  logic                   wr_ready;
  logic                   flush;
  logic                   tx_busy;
  logic [UART_DATA_W-1:0] tx_data;
  logic                   tx_start;
  logic [ADDR_W:0]        count;
  logic                   empty;
  logic                   full;
  logic                   overflow;

  // Host/transmitter side.
  modport master (
    output wr_data, wr_valid, flush, tx_busy,
    input  wr_ready, tx_data, tx_start, count, empty, full, overflow
  );

  // Buffer side.
  modport slave (
    input  wr_data, wr_valid, flush, tx_busy,
    output wr_ready, tx_data, tx_start, count, empty, full, overflow
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Circular byte FIFO with a separate occupancy counter.
//   clk, rst : clock, synchronous active-high reset
//   flush    : clears pointers and count; overrides push and pop
//   push     : write wr_data at the tail
//   pop      : advance the head
//   head     : byte at the head (combinational read)
//   count    : occupancy 0..DEPTH; full/empty derived from it
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [UART_DATA_W-1:0] wr_data,
  output logic [UART_DATA_W-1:0] head,
  output logic [ADDR_W:0]        count,
  output logic                   full,
  output logic                   empty
);

  localparam logic [ADDR_W:0]   CntFull = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CntOne  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PtrOne  = ADDR_W'(1);

  logic [UART_DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]        count_q;
  logic                   do_push, do_pop;

  assign full  = (count_q == CntFull);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem[rd_ptr_q];

  // Guard locally too so the FIFO cannot corrupt itself whatever the caller does.
  assign do_push = push && !flush && !full;
  assign do_pop  = pop  && !flush && !empty;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntOne;
        2'b01:   count_q <= count_q - CntOne;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit-side byte buffer feeding the UART transmitter one frame at a time.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of uart_tx_fifo_if (host write handshake, flush,
//              transmitter start/busy handshake, status and sticky overflow)
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input logic           clk,
  input logic           rst,
  uart_tx_fifo_if.slave bus
);

  tx_state_e              state_q;
  logic [UART_DATA_W-1:0] tx_data_q;
  logic                   tx_start_q;
  logic                   overflow_q;
  logic [UART_DATA_W-1:0] head;
  logic                   full, empty;
  logic                   push, pop;

  assign bus.wr_ready = !full && !bus.flush;
  assign push         = bus.wr_valid && bus.wr_ready;
  // Only launch when the transmitter is idle; flush takes priority over a pop.
  assign pop          = (state_q == StIdle) && !empty && !bus.tx_busy && !bus.flush;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (bus.flush),
    .push    (push),
    .pop     (pop),
    .wr_data (bus.wr_data),
    .head    (head),
    .count   (bus.count),
    .full    (full),
    .empty   (empty)
  );

  // Flush does not touch the FSM: a launched frame is allowed to finish.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (pop) begin
            tx_data_q  <= head;
            tx_start_q <= 1'b1;
            state_q    <= StStart;
          end
        end
        StStart:    state_q <= StWaitAck;
        StWaitAck:  if (bus.tx_busy)  state_q <= StWaitDone;
        StWaitDone: if (!bus.tx_busy) state_q <= StIdle;
        default:    state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      overflow_q <= 1'b0;
    end else if (bus.wr_valid && full) begin
      overflow_q <= 1'b1;
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.overflow = overflow_q;

endmodule
